fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the pipeline register walls. Generates the PC, runs a req/ack handshake to instruction memory, and buffers fetched words in a 2-entry queue.
- Presents the queue head as the instruction for the REG1 wall and drives that wall's flush input whenever no valid instruction is available.
- Handles redirects (taken branch/jump) and pipeline stalls (hazard hold).

---
 rtl/fetch_unit_pkg.sv | 29 ++
 rtl/fetch_unit_if.sv | 13 +
 rtl/fetch_queue.sv | 55 +++++
 rtl/fetch_unit.sv | 116 +++++++++++
 tb/tb_fetch_unit.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types and constants: state encoding, queue entry layout,
// reset defaults.
package fetch_unit_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned QUEUE_DEPTH = 2;
  localparam int unsigned COUNT_W     = 2;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned     DEFAULT_PC_STEP  = 4;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    KILL = 2'd2
  } fetchState_t;

  typedef struct packed {
    logic [XLEN-1:0] word;
    logic [XLEN-1:0] pc;
  } queueEntry_t;

  // Redirect targets are word aligned; the low two bits are dropped.
  function automatic logic [XLEN-1:0] alignPc(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge channel between the fetch unit
// (master) and instruction memory (slave).
interface fetch_unit_if;

  logic                            im_req;
  logic [fetch_unit_pkg::XLEN-1:0] im_addr;
  logic                            im_ack;
  logic [fetch_unit_pkg::XLEN-1:0] im_rdata;

  modport master (output im_req, output im_addr, input im_ack, input im_rdata);
  modport slave  (input im_req, input im_addr, output im_ack, output im_rdata);

endinterface

// File: rtl/fetch_queue.sv
// Two-entry {word, pc} FIFO between instruction memory and the REG1 wall.
// Head reads as a NOP at PC 0 when empty.
module fetch_queue
  import fetch_unit_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic               clear,
  input  queueEntry_t        pushEntry,
  output queueEntry_t        headEntry,
  output logic [COUNT_W-1:0] count
);

  queueEntry_t        slot0;
  queueEntry_t        slot1;
  logic [COUNT_W-1:0] countReg;

  // slot0 is always the head; slot1 only holds data when two entries are live.
  always_ff @(posedge clock) begin
    if (reset) begin
      countReg <= '0;
      slot0    <= '0;
      slot1    <= '0;
    end else if (clear) begin
      countReg <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (countReg == '0) slot0 <= pushEntry;
          else                slot1 <= pushEntry;
          countReg <= countReg + COUNT_W'(1);
        end
        2'b01: begin
          slot0    <= slot1;
          countReg <= countReg - COUNT_W'(1);
        end
        2'b11: begin
          if (countReg == COUNT_W'(QUEUE_DEPTH)) begin
            slot0 <= slot1;
            slot1 <= pushEntry;
          end else begin
            slot0 <= pushEntry;
          end
        end
        default: ;
      endcase
    end
  end

  assign headEntry = (countReg != '0) ? slot0 : queueEntry_t'{word: NOP_INSTR, pc: '0};
  assign count     = countReg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, req/ack memory handshake with
// redirect kill, and a 2-entry queue feeding the REG1 wall.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned     PC_STEP  = DEFAULT_PC_STEP
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable_fetch,
  input  logic            do_hazard,
  input  logic            do_branch,
  input  logic [XLEN-1:0] branch_target,
  fetch_unit_if.master    mem,
  output logic [XLEN-1:0] oIF_instruction,
  output logic [XLEN-1:0] oIF_pc,
  output logic            oIF_valid,
  output logic            do_flush_REG1
);

  fetchState_t        state;
  fetchState_t        stateNext;
  logic [XLEN-1:0]    fetchPc;
  logic [XLEN-1:0]    fetchPcNext;
  logic [XLEN-1:0]    imAddr;
  logic [XLEN-1:0]    imAddrNext;
  logic               push;
  logic               pop;
  logic               issue;
  logic               canIssue;
  logic [COUNT_W-1:0] count;
  logic [COUNT_W-1:0] countNext;
  queueEntry_t        headEntry;

  assign pop  = enable_fetch && !do_hazard && oIF_valid && !do_branch;
  assign push = (state == BUSY) && mem.im_ack && !do_branch;

  // Issuing only when the post-update queue has room reserves a slot for every live ack.
  assign countNext = do_branch ? '0 : count + COUNT_W'(push) - COUNT_W'(pop);
  assign canIssue  = enable_fetch && !do_branch && (countNext < COUNT_W'(QUEUE_DEPTH));

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      fetchPc <= RESET_PC;
      imAddr  <= RESET_PC;
    end else begin
      state   <= stateNext;
      fetchPc <= fetchPcNext;
      imAddr  <= imAddrNext;
    end
  end

  always_comb begin
    stateNext   = state;
    fetchPcNext = fetchPc;
    imAddrNext  = imAddr;
    issue       = 1'b0;

    case (state)
      IDLE: begin
        if (do_branch) begin
          fetchPcNext = alignPc(branch_target);
        end else if (canIssue) begin
          issue     = 1'b1;
          stateNext = BUSY;
        end
      end
      BUSY: begin
        if (mem.im_ack) begin
          if (do_branch) begin
            fetchPcNext = alignPc(branch_target);
            stateNext   = IDLE;
          end else if (canIssue) begin
            issue = 1'b1;
          end else begin
            stateNext = IDLE;
          end
        end else if (do_branch) begin
          fetchPcNext = alignPc(branch_target);
          stateNext   = KILL;
        end
      end
      KILL: begin
        if (do_branch) fetchPcNext = alignPc(branch_target);
        if (mem.im_ack) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase

    if (issue) begin
      imAddrNext  = fetchPc;
      fetchPcNext = fetchPc + XLEN'(PC_STEP);
    end
  end

  fetch_queue uQueue (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .clear     (do_branch),
    .pushEntry (queueEntry_t'{word: mem.im_rdata, pc: imAddr}),
    .headEntry (headEntry),
    .count     (count)
  );

  assign mem.im_req      = (state != IDLE);
  assign mem.im_addr     = imAddr;
  assign oIF_valid       = (count != '0);
  assign oIF_instruction = headEntry.word;
  assign oIF_pc          = headEntry.pc;
  assign do_flush_REG1   = !oIF_valid || do_branch;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus hand sequences for
// kill, redirect-on-ack, reset mid-request and address wrap.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable_fetch = 1'b0;
  logic        do_hazard = 1'b0;
  logic        do_branch = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic [31:0] oIF_instruction;
  logic [31:0] oIF_pc;
  logic        oIF_valid;
  logic        do_flush_REG1;

  int checks = 0;
  int failures = 0;

  // Memory model: ack in the memLat-th cycle of a request, word = addr ^ A5A5_0000.
  int memLat = 1;
  bit memOn = 1'b1;
  bit forceAck = 1'b0;
  int waitCnt = 0;

  fetch_unit_if mem();

  fetch_unit dut (
    .clock           (clock),
    .reset           (reset),
    .enable_fetch    (enable_fetch),
    .do_hazard       (do_hazard),
    .do_branch       (do_branch),
    .branch_target   (branch_target),
    .mem             (mem),
    .oIF_instruction (oIF_instruction),
    .oIF_pc          (oIF_pc),
    .oIF_valid       (oIF_valid),
    .do_flush_REG1   (do_flush_REG1)
  );

  always #5 clock = ~clock;

  assign mem.im_ack   = forceAck || (memOn && mem.im_req && (waitCnt == memLat - 1));
  assign mem.im_rdata = forceAck ? 32'hDEAD_BEEF : (mem.im_addr ^ 32'hA5A5_0000);

  always @(posedge clock) begin
    if (reset || !mem.im_req || mem.im_ack) waitCnt <= 0;
    else waitCnt <= waitCnt + 1;
  end

  typedef struct {
    logic        en;
    logic        haz;
    logic        br;
    logic [31:0] tgt;
    logic        eReq;
    logic [31:0] eAddr;
    logic        eValid;
    logic [31:0] ePc;
    logic        eFlush;
  } vec_t;

  vec_t vecs[26];

  function automatic vec_t mk(input logic en, input logic haz, input logic br,
                              input logic [31:0] tgt, input logic eReq,
                              input logic [31:0] eAddr, input logic eValid,
                              input logic [31:0] ePc, input logic eFlush);
    vec_t v;
    v.en = en; v.haz = haz; v.br = br; v.tgt = tgt;
    v.eReq = eReq; v.eAddr = eAddr; v.eValid = eValid; v.ePc = ePc; v.eFlush = eFlush;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkOut(input string tag, input logic eReq, input logic [31:0] eAddr,
                        input logic eValid, input logic [31:0] ePc, input logic eFlush);
    logic [31:0] eInstr;
    eInstr = eValid ? (ePc ^ 32'hA5A5_0000) : 32'h0;
    chk({tag, " im_req"}, 32'(mem.im_req), 32'(eReq));
    chk({tag, " im_addr"}, mem.im_addr, eAddr);
    chk({tag, " valid"}, 32'(oIF_valid), 32'(eValid));
    chk({tag, " pc"}, oIF_pc, eValid ? ePc : 32'h0);
    chk({tag, " instr"}, oIF_instruction, eInstr);
    chk({tag, " flush"}, 32'(do_flush_REG1), 32'(eFlush));
  endtask

  task automatic drive(input logic en, input logic haz, input logic br, input logic [31:0] tgt);
    enable_fetch  = en;
    do_hazard     = haz;
    do_branch     = br;
    branch_target = tgt;
  endtask

  // Pulses reset, checks reset outputs, returns at the start of cycle 0 after release.
  task automatic startRun(input int lat);
    @(negedge clock);
    reset    = 1'b1;
    forceAck = 1'b0;
    memOn    = 1'b1;
    memLat   = lat;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(negedge clock);
    #1 chkOut("reset", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    @(negedge clock);
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit sawReq;
    int n;

    // en, haz, br, tgt | req, addr, valid, pc, flush
    vecs[0]  = mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b1);
    vecs[1]  = mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0,   1'b1);
    vecs[2]  = mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   1'b1, 32'h0,   1'b0);
    vecs[3]  = mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h4,   1'b0);
    vecs[4]  = mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'hC,   1'b1, 32'h8,   1'b0);
    vecs[5]  = mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'hC,   1'b1, 32'h8,   1'b0);
    vecs[6]  = mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'hC,   1'b1, 32'h8,   1'b0);
    vecs[7]  = mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'hC,   1'b1, 32'h8,   1'b0);
    vecs[8]  = mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'hC,   1'b1, 32'h8,   1'b0);
    vecs[9]  = mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'hC,   1'b1, 32'h8,   1'b0);
    vecs[10] = mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'hC,   1'b0);
    vecs[11] = mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h14,  1'b1, 32'h10,  1'b0);
    vecs[12] = mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h18,  1'b1, 32'h14,  1'b0);
    vecs[13] = mk(1'b1, 1'b1, 1'b1, 32'h103, 1'b0, 32'h18,  1'b1, 32'h14,  1'b1);
    vecs[14] = mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h18,  1'b0, 32'h0,   1'b1);
    vecs[15] = mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0,   1'b1);
    vecs[16] = mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1, 32'h100, 1'b0);
    vecs[17] = mk(1'b1, 1'b0, 1'b1, 32'h200, 1'b1, 32'h108, 1'b1, 32'h104, 1'b1);
    vecs[18] = mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h108, 1'b0, 32'h0,   1'b1);
    vecs[19] = mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h0,   1'b1);
    vecs[20] = mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h204, 1'b1, 32'h200, 1'b0);
    vecs[21] = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h208, 1'b1, 32'h204, 1'b0);
    vecs[22] = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h208, 1'b1, 32'h204, 1'b0);
    vecs[23] = mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h208, 1'b1, 32'h204, 1'b0);
    vecs[24] = mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h20C, 1'b1, 32'h208, 1'b0);
    vecs[25] = mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h210, 1'b1, 32'h20C, 1'b0);

    // Streaming, hazard hold, redirect with full queue, redirect on ack, enable low.
    startRun(1);
    for (int k = 0; k < 26; k++) begin
      if (k != 0) @(negedge clock);
      drive(vecs[k].en, vecs[k].haz, vecs[k].br, vecs[k].tgt);
      #1 chkOut($sformatf("vec%0d", k), vecs[k].eReq, vecs[k].eAddr,
                vecs[k].eValid, vecs[k].ePc, vecs[k].eFlush);
    end

    // Redirect while a 3-cycle request is outstanding: its word must never surface.
    startRun(3);
    drive(1'b1, 1'b0, 1'b1, 32'h10);
    #1 chkOut("kill c0", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    @(negedge clock); drive(1'b1, 1'b0, 1'b0, 32'h0);
    #1 chkOut("kill c1", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    @(negedge clock); drive(1'b1, 1'b0, 1'b1, 32'h200);
    #1 chkOut("kill c2", 1'b1, 32'h10, 1'b0, 32'h0, 1'b1);
    @(negedge clock); drive(1'b1, 1'b0, 1'b0, 32'h0);
    #1 chkOut("kill c3", 1'b1, 32'h10, 1'b0, 32'h0, 1'b1);
    @(negedge clock);
    #1 chkOut("kill c4", 1'b1, 32'h10, 1'b0, 32'h0, 1'b1);
    @(negedge clock);
    #1 chkOut("kill c5", 1'b0, 32'h10, 1'b0, 32'h0, 1'b1);
    sawReq = 1'b0;
    n = 0;
    while (n < 20 && !oIF_valid) begin
      @(negedge clock);
      #1;
      if (!sawReq && mem.im_req) begin
        sawReq = 1'b1;
        chk("kill next addr", mem.im_addr, 32'h200);
      end
      n++;
    end
    chk("kill valid seen", 32'(oIF_valid), 32'h1);
    chk("kill first pc", oIF_pc, 32'h200);
    chk("kill first instr", oIF_instruction, 32'hA5A5_0200);

    // Reset while BUSY, then a stray ack during IDLE.
    startRun(1);
    #1 chkOut("rst c0", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    @(negedge clock);
    #1 chkOut("rst c1", 1'b1, 32'h0, 1'b0, 32'h0, 1'b1);
    @(negedge clock);
    #1 chkOut("rst c2", 1'b1, 32'h4, 1'b1, 32'h0, 1'b0);
    @(negedge clock);
    memOn = 1'b0;
    reset = 1'b1;
    #1 chkOut("rst c3", 1'b1, 32'h8, 1'b1, 32'h4, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    forceAck = 1'b1;
    #1 chkOut("rst c4", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    @(negedge clock);
    forceAck = 1'b0;
    memOn = 1'b1;
    #1 chkOut("rst c5", 1'b1, 32'h0, 1'b0, 32'h0, 1'b1);
    @(negedge clock);
    #1 chkOut("rst c6", 1'b1, 32'h4, 1'b1, 32'h0, 1'b0);

    // Address wrap: unaligned target near the top of the space.
    startRun(1);
    drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
    #1 chkOut("wrap c0", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    @(negedge clock); drive(1'b1, 1'b0, 1'b0, 32'h0);
    #1 chkOut("wrap c1", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    @(negedge clock);
    #1 chkOut("wrap c2", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1);
    @(negedge clock);
    #1 chkOut("wrap c3", 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    @(negedge clock);
    #1 chkOut("wrap c4", 1'b1, 32'h4, 1'b1, 32'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
